data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Parameters
REQ-001 SHALL have parameter MAX_WAIT, default 4: the number of consecutive cycles port B may be denied before it is forced to win.
REQ-002 SHALL have parameter BURST_MAX, default 8: the maximum number of back-to-back port B grants while b_lock is high.

Interface
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: cancels the port A request in the current cycle.
REQ-006 SHALL have ports req_a/we_a, input, 1 bit each: pipeline memory-stage request / write enable.
REQ-007 SHALL have ports addr_a/wdata_a, input, 8 bits each: pipeline address / write data.
REQ-008 SHALL have ports req_b/we_b/b_lock, input, 1 bit each: loader/debug request / write enable / burst lock.
REQ-009 SHALL have ports addr_b/wdata_b, input, 8 bits each: loader address / write data.
REQ-010 SHALL have ports gnt_a/gnt_b, output, 1 bit each: combinational grant; the access is issued in this cycle.
REQ-011 SHALL have ports rvalid_a/rvalid_b, output, 1 bit each: read data valid, registered.
REQ-012 SHALL have ports rdata_a/rdata_b, output, 8 bits each: read data returned to each requester.
REQ-013 SHALL have ports mem_en/mem_we, output, 1 bit each: memory access strobe / write strobe.
REQ-014 SHALL have ports mem_addr/mem_wdata, output, 8 bits each: memory address / write data.
REQ-015 SHALL have port mem_rdata, input, 8 bits: memory read data, valid one cycle after a read strobe.
REQ-016 SHALL have port starve_b, output, 1 bit: high while the wait counter equals MAX_WAIT.

Function
REQ-017 SHALL treat a request as valid/hold: the requester keeps req and its fields stable until it sees gnt in the same cycle.
REQ-018 SHALL define the effective A request as eff_a = req_a & ~flush; a flushed A request SHALL NOT be granted or written.
REQ-019 SHALL implement FSM states ARB and BURST_B.
REQ-020 In ARB, SHALL grant A if eff_a is high and starve_b is low; otherwise SHALL grant B if req_b is high.
REQ-021 SHALL assert at most one grant per cycle; if neither port requests, no grant and mem_en=0.
REQ-022 SHALL transition ARB->BURST_B when B is granted with b_lock=1, and load burst_cnt=1.
REQ-023 In BURST_B, SHALL grant B whenever req_b=1 regardless of eff_a, and increment burst_cnt on each grant.
REQ-024 SHALL return BURST_B->ARB when b_lock=0, or req_b=0, or a grant brings burst_cnt to BURST_MAX; that grant completes normally.
REQ-025 SHALL increment wait_b (saturating at MAX_WAIT) each cycle req_b=1 and gnt_b=0; SHALL clear it on gnt_b or when req_b=0.
REQ-026 SHALL drive the mem_* outputs from the granted port: mem_en=gnt_a|gnt_b, mem_we=granted we, mem_addr/mem_wdata=granted fields; all are 0 when idle.
REQ-027 SHALL, on a granted read (we=0), assert rvalid of that port exactly one cycle later with rdata equal to mem_rdata; a granted write SHALL produce no rvalid.
REQ-028 SHALL hold rdata_a/rdata_b at their last values when rvalid is low.
REQ-029 SHALL complete a read granted in cycle N (rvalid in N+1) even if flush asserts in N+1.
REQ-030 SHALL allow grants in consecutive cycles, giving full throughput of one access per cycle.
REQ-031 SHALL ignore we_a/we_b, addr and wdata of the non-granted port.

Reset
REQ-032 SHALL, while reset=0, asynchronously force state=ARB, wait_b=0, burst_cnt=0, rvalid_a=rvalid_b=0, rdata_a=rdata_b=0x00 and starve_b=0.
REQ-033 SHALL hold gnt_a, gnt_b and mem_en at 0 while reset=0, regardless of requests.
REQ-034 SHALL drop an in-flight read when reset is asserted, so that no rvalid appears after release.

Verification
REQ-035 SHALL cover: A reads addr 0x10 while memory holds 0x5A -> gnt_a in cycle N, rvalid_a=1 and rdata_a=0x5A in N+1, B idle.
REQ-036 SHALL cover: A and B request continuously, MAX_WAIT=4 -> A granted 4 cycles, starve_b=1, B granted on the 5th cycle, wait_b=0.
REQ-037 SHALL cover: A writes 0x33 to 0x20 with flush=1 in the same cycle -> gnt_a=0, mem_en=0, a later read of 0x20 returns the old value.
REQ-038 SHALL cover: B writes with b_lock=1 and req_a held -> 8 consecutive gnt_b, then ARB, then gnt_a next cycle.
REQ-039 SHALL cover: reset pulled low the cycle after a granted B read -> rvalid_b never asserts, all outputs 0, normal operation after release.
REQ-040 SHALL cover: B read then A read back-to-back -> rvalid_b then rvalid_a on consecutive cycles with correct data, no cross-routing.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: pipeline port A normally wins, loader port B is
// protected from starvation and may lock the memory for bounded write/read bursts.
module data_mem_arbiter #(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       req_a,
  input  logic       we_a,
  input  logic [7:0] addr_a,
  input  logic [7:0] wdata_a,
  input  logic       req_b,
  input  logic       we_b,
  input  logic       b_lock,
  input  logic [7:0] addr_b,
  input  logic [7:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       rvalid_a,
  output logic       rvalid_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       starve_b
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIMIT  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(BURST_MAX);

  typedef enum logic {ARB, BURST_B} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [WW-1:0] r_wait_b;
  logic [BW-1:0] r_burst_cnt;
  logic [BW-1:0] w_burst_next;
  logic [BW-1:0] w_burst_inc;
  logic          w_eff_a;
  logic          w_gnt_a;
  logic          w_gnt_b;
  logic          r_rvalid_a;
  logic          r_rvalid_b;
  logic [7:0]    r_rdata_a;
  logic [7:0]    r_rdata_b;

  assign w_eff_a     = req_a & ~flush;
  assign w_burst_inc = r_burst_cnt + 1'b1;
  assign starve_b    = (r_wait_b == WAIT_LIMIT);

  always_comb begin
    w_gnt_a      = 1'b0;
    w_gnt_b      = 1'b0;
    w_state_next = r_state;
    w_burst_next = r_burst_cnt;
    case (r_state)
      ARB: begin
        if (w_eff_a && !starve_b) begin
          w_gnt_a = 1'b1;
        end else if (req_b) begin
          w_gnt_b = 1'b1;
          if (b_lock && BURST_MAX > 1) begin
            w_state_next = BURST_B;
            w_burst_next = BW'(1);
          end
        end
      end
      BURST_B: begin
        if (req_b) begin
          w_gnt_b      = 1'b1;
          w_burst_next = w_burst_inc;
        end
        // The closing grant still completes; only the lock is released.
        if (!b_lock || !req_b || w_burst_inc == BURST_LIMIT) begin
          w_state_next = ARB;
          w_burst_next = '0;
        end
      end
      default: w_state_next = ARB;
    endcase
  end

  assign gnt_a = w_gnt_a & reset;
  assign gnt_b = w_gnt_b & reset;

  always_comb begin
    mem_en    = gnt_a | gnt_b;
    mem_we    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 8'h00;
    if (gnt_a) begin
      mem_we    = we_a;
      mem_addr  = addr_a;
      mem_wdata = wdata_a;
    end else if (gnt_b) begin
      mem_we    = we_b;
      mem_addr  = addr_b;
      mem_wdata = wdata_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ARB;
      r_burst_cnt <= '0;
      r_wait_b    <= '0;
      r_rvalid_a  <= 1'b0;
      r_rvalid_b  <= 1'b0;
      r_rdata_a   <= 8'h00;
      r_rdata_b   <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_burst_cnt <= w_burst_next;
      if (req_b && !gnt_b) begin
        r_wait_b <= starve_b ? r_wait_b : r_wait_b + 1'b1;
      end else begin
        r_wait_b <= '0;
      end
      r_rvalid_a <= gnt_a & ~we_a;
      r_rvalid_b <= gnt_b & ~we_b;
      if (r_rvalid_a) r_rdata_a <= mem_rdata;
      if (r_rvalid_b) r_rdata_b <= mem_rdata;
    end
  end

  // Read data arrives from memory in the rvalid cycle; the registers only hold it afterwards.
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign rdata_a  = r_rvalid_a ? mem_rdata : r_rdata_a;
  assign rdata_b  = r_rvalid_b ? mem_rdata : r_rdata_b;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: stimulus checks grants and pushes expected
// read data; an independent monitor pops and compares whenever rvalid appears.
module tb_data_mem_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       flush, req_a, we_a, req_b, we_b, b_lock;
  logic [7:0] addr_a, wdata_a, addr_b, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b, mem_en, mem_we, starve_b;
  logic [7:0] rdata_a, rdata_b, mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  data_mem_arbiter #(.MAX_WAIT(4), .BURST_MAX(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .b_lock(b_lock), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .starve_b(starve_b)
  );

  // Simple synchronous memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end else begin
      $display("ok   %s: %02h", name, act);
    end
  endtask

  task automatic idle();
    flush = 0; req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; b_lock = 0; addr_b = 0; wdata_b = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_a(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    req_a = 1; we_a = we; addr_a = addr; wdata_a = wd;
  endtask

  task automatic drive_b(input logic we, input logic [7:0] addr, input logic [7:0] wd, input logic lock);
    req_b = 1; we_b = we; addr_b = addr; wdata_b = wd; b_lock = lock;
  endtask

  // Monitor: every rvalid must match the oldest expected read for that port
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (rvalid_a) begin
          if (q_a.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rvalid_a_unexpected: got rvalid_a=1 expected 0 (data %02h)", rdata_a);
          end else chk("rdata_a", rdata_a, q_a.pop_front());
        end
        if (rvalid_b) begin
          if (q_b.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rvalid_b_unexpected: got rvalid_b=1 expected 0 (data %02h)", rdata_b);
          end else chk("rdata_b", rdata_b, q_b.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem[8'h20] = 8'h77;
    mem_rdata = 8'h00;
    idle();
    reset = 0;

    // Reset state with requests present
    step();
    drive_a(1'b0, 8'h10, 8'h00);
    drive_b(1'b0, 8'h20, 8'h00, 1'b1);
    @(negedge clk);
    chk("rst_gnt_a", {7'b0, gnt_a}, 8'h00);
    chk("rst_gnt_b", {7'b0, gnt_b}, 8'h00);
    chk("rst_mem_en", {7'b0, mem_en}, 8'h00);
    chk("rst_rvalid", {6'b0, rvalid_a, rvalid_b}, 8'h00);
    chk("rst_rdata_a", rdata_a, 8'h00);
    chk("rst_starve_b", {7'b0, starve_b}, 8'h00);
    step(); idle(); reset = 1;

    // A reads 0x10 -> 0x5A next cycle
    step();
    drive_a(1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("a_rd_gnt_a", {7'b0, gnt_a}, 8'h01);
    chk("a_rd_gnt_b", {7'b0, gnt_b}, 8'h00);
    chk("a_rd_mem_addr", mem_addr, 8'h10);
    chk("a_rd_mem_we", {7'b0, mem_we}, 8'h00);
    q_a.push_back(8'h5A);
    step(); idle();

    // Flushed write must not happen; later read returns old value
    step();
    drive_a(1'b1, 8'h20, 8'h33); flush = 1;
    @(negedge clk);
    chk("flush_gnt_a", {7'b0, gnt_a}, 8'h00);
    chk("flush_mem_en", {7'b0, mem_en}, 8'h00);
    step(); idle();
    drive_a(1'b0, 8'h20, 8'h00);
    @(negedge clk);
    chk("flush_rd_gnt_a", {7'b0, gnt_a}, 8'h01);
    q_a.push_back(8'h77);
    step(); idle();

    // Starvation: A wins 4 cycles, then B forced through
    step();
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b0, 8'h10, 8'h00);
      drive_b(1'b1, 8'h40, 8'h11, 1'b0);
      @(negedge clk);
      chk($sformatf("starve_gnt_a_%0d", k), {7'b0, gnt_a}, 8'h01);
      chk($sformatf("starve_flag_%0d", k), {7'b0, starve_b}, 8'h00);
      q_a.push_back(8'h5A);
      step();
    end
    @(negedge clk);
    chk("starve_flag_4", {7'b0, starve_b}, 8'h01);
    chk("starve_gnt_b", {7'b0, gnt_b}, 8'h01);
    chk("starve_gnt_a_4", {7'b0, gnt_a}, 8'h00);
    chk("starve_mem_addr", mem_addr, 8'h40);
    chk("starve_mem_wdata", mem_wdata, 8'h11);
    step();
    req_b = 0;
    @(negedge clk);
    chk("starve_cleared", {7'b0, starve_b}, 8'h00);
    chk("starve_gnt_a_5", {7'b0, gnt_a}, 8'h01);
    q_a.push_back(8'h5A);
    step(); idle();

    // Locked B burst: 8 writes even with A requesting, then A
    step();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) drive_a(1'b0, 8'h10, 8'h00);
      drive_b(1'b1, 8'h50 + 8'(i), 8'h80 + 8'(i), 1'b1);
      @(negedge clk);
      chk($sformatf("burst_gnt_b_%0d", i), {7'b0, gnt_b}, 8'h01);
      chk($sformatf("burst_gnt_a_%0d", i), {7'b0, gnt_a}, 8'h00);
      step();
    end
    req_b = 0; b_lock = 0;
    @(negedge clk);
    chk("burst_end_gnt_a", {7'b0, gnt_a}, 8'h01);
    q_a.push_back(8'h5A);
    step(); idle();

    // B read then A read back-to-back
    drive_b(1'b0, 8'h53, 8'h00, 1'b0);
    @(negedge clk);
    chk("b2b_gnt_b", {7'b0, gnt_b}, 8'h01);
    q_b.push_back(8'h83);
    step(); idle();
    drive_a(1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("b2b_gnt_a", {7'b0, gnt_a}, 8'h01);
    q_a.push_back(8'h5A);
    step(); idle();
    step();
    @(negedge clk);
    chk("hold_rdata_a", rdata_a, 8'h5A);
    chk("hold_rdata_b", rdata_b, 8'h83);

    // Reset right after a granted B read drops the read
    step();
    drive_b(1'b0, 8'h57, 8'h00, 1'b0);
    @(negedge clk);
    chk("rst_rd_gnt_b", {7'b0, gnt_b}, 8'h01);
    #1 reset = 0;
    drive_a(1'b0, 8'h10, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst2_gnts_%0d", k), {6'b0, gnt_a, gnt_b}, 8'h00);
      chk($sformatf("rst2_mem_en_%0d", k), {7'b0, mem_en}, 8'h00);
      chk($sformatf("rst2_rvalid_%0d", k), {6'b0, rvalid_a, rvalid_b}, 8'h00);
      chk($sformatf("rst2_rdata_b_%0d", k), rdata_b, 8'h00);
    end
    step(); idle(); reset = 1;
    @(negedge clk);
    chk("post_rst_rvalid_b", {7'b0, rvalid_b}, 8'h00);
    step();
    drive_a(1'b0, 8'h20, 8'h00);
    @(negedge clk);
    chk("post_rst_gnt_a", {7'b0, gnt_a}, 8'h01);
    q_a.push_back(8'h77);
    step(); idle();

    repeat (3) step();
    chk("q_a_drained", 8'(q_a.size()), 8'h00);
    chk("q_b_drained", 8'(q_b.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
